encoder8x3_pri: RTL and testbench
=================================

Name: encoder8x3_pri

Overview:
- Sequential 8-to-3 priority encoder; the inverse of the 3x8 decoder tree.
- Latches eight request lines into a pending register and presents one 3-bit index at a time on a valid/ready output handshake.
- Clears each request once its index is accepted.
- Sits between request sources (per-line strobes) and a consumer that drives the 3x8 decoder or indexes a table.

Parameters:
- HIGH_FIRST, 1, priority order: 1 = highest index wins (a7 over a0); 0 = lowest index wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- en  input  1  enable: 1 = capture requests and start new selections; 0 = freeze capture and selection.
- req  input  8  request lines; req[i] high at a rising edge sets pending bit i.
- out_code  output  3  encoded index {x2,x1,x0} of the presented request.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code when out_valid && out_ready at an edge.
- pending  output  8  current pending register, for visibility.
- lost  output  1  sticky; set when a request is dropped; cleared only by rst.

Behaviour:
- Reset (rst=1, asynchronous): pending=0, out_code=0, out_valid=0, lost=0, FSM=IDLE. Reset takes effect mid-transfer with no completion.

Capture (en=1):
- pending_next = (pending & ~clr) | req.
- clr = one-hot of out_code when out_valid && out_ready, else 0.
- If req[i] and clr[i] are both 1 in the same cycle, the new request wins and bit i stays set. That request is not lost.
- lost is set if req[i]=1 while pending[i]=1 and bit i is not being cleared that cycle.
- en=0: req is ignored, pending holds except for clr, and lost does not update.

FSM, states IDLE and HOLD:
- IDLE, out_valid=0: if en=1 and pending != 0 at an edge, load out_code = select(pending), set out_valid=1, go to HOLD. Otherwise stay.
- HOLD, out_valid=1: out_code is stable while out_ready=0; en=0 does not withdraw it. When out_valid && out_ready:
  - Let rem = pending & ~clr.
  - If en=1 and rem != 0: out_code = select(rem), stay in HOLD. This is back-to-back, one index per cycle.
  - Otherwise: out_valid=0, out_code holds its last value, go to IDLE.
- select() is the registered priority pick over the current pending register only. req arriving in the same cycle is not considered.

Latency and priority:
- Latency: req high at edge k → pending set after edge k → out_valid/out_code after edge k+1 (2 cycles, idle encoder).
- Priority is re-evaluated only when a new code is loaded. A higher-priority request arriving during HOLD does not preempt the presented code.

Width and invariants:
- Index i maps to out_code = i[2:0]; no other arithmetic.
- out_valid=1 implies pending[out_code]=1.

Test Plan:
- Reset → pending=0, out_valid=0, out_code=0, lost=0. Then req=8'h00 for 5 cycles → out_valid stays 0.
- HIGH_FIRST=1, out_ready=1, one-cycle req=8'b1010_0100 → codes 7, 5, 2 on three consecutive cycles starting 2 cycles after req. Then out_valid=0 and pending=0.
- HIGH_FIRST=0, same stimulus → codes 2, 5, 7.
- out_ready=0 with code 3 presented; pulse req[6] → out_code stays 3, pending=8'b0100_1000. Raise out_ready → codes 3 then 6.
- Presenting code 4 with out_ready=1, and req[4]=1 on the accepting edge → pending[4] stays 1, code 4 presented again next, lost=0. Then req[1] twice while pending[1]=1 and out_ready=0 → lost=1.
- en=0 while code 2 is presented, pending=8'b0000_0101, req=8'hFF → accept clears bit 2, out_valid drops, pending=8'b0000_0001, req is ignored. Then en=1 → code 0.
- Assert rst mid-HOLD → all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/encoder8x3_pri_if.sv
// Handshake and status bundle for the sequential 8-to-3 priority encoder.
// The slave side is the encoder; the master side is the request source / consumer.
interface encoder8x3_pri_if;
    logic       en;
    logic [7:0] req;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       lost;

    modport slave (
        input  en,
        input  req,
        input  out_ready,
        output out_code,
        output out_valid,
        output pending,
        output lost
    );

    modport master (
        output en,
        output req,
        output out_ready,
        input  out_code,
        input  out_valid,
        input  pending,
        input  lost
    );
endinterface

// File: rtl/encoder8x3_pri.sv
// Sequential 8-to-3 priority encoder.
// Request strobes are latched into a pending register; one index at a time is
// offered on a valid/ready handshake and its pending bit is cleared on accept.
module encoder8x3_pri #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    encoder8x3_pri_if.slave         bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_pending;
    logic [2:0] r_code;
    logic       r_lost;

    logic       w_accept;
    logic [7:0] w_clr;
    logic [7:0] w_rem;
    logic [7:0] w_pending_nxt;
    logic       w_lost_set;

    // Priority pick over a pending vector; the last hit in scan order wins.
    function automatic logic [2:0] f_select(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++)
                if (v[i]) idx = i[2:0];
        end else begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    // Accept clears the presented bit; a same-cycle request re-sets it, and a
    // request hitting a still-pending bit is counted as lost.
    always_comb begin
        w_accept      = (r_state == HOLD) && bus.out_ready;
        w_clr         = w_accept ? (8'b1 << r_code) : 8'b0;
        w_rem         = r_pending & ~w_clr;
        w_pending_nxt = bus.en ? (w_rem | bus.req) : w_rem;
        w_lost_set    = bus.en && |(bus.req & w_rem);
    end

    // Pending register and sticky loss flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 8'h00;
            r_lost    <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_lost_set) r_lost <= 1'b1;
        end
    end

    // Presentation FSM: selection uses only the registered pending vector, so a
    // request arriving this cycle never preempts or joins the current pick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_code  <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.en && (r_pending != 8'h00)) begin
                        r_code  <= f_select(r_pending);
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        if (bus.en && (w_rem != 8'h00)) begin
                            r_code <= f_select(w_rem);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_code  = r_code;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.pending   = r_pending;
    assign bus.lost      = r_lost;
endmodule

// File: tb/tb_encoder8x3_pri.sv
// Directed bench for encoder8x3_pri: one instance per priority order.
module tb_encoder8x3_pri;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    encoder8x3_pri_if if_hi ();
    encoder8x3_pri_if if_lo ();

    encoder8x3_pri #(.HIGH_FIRST(1'b1)) u_hi (.clk(clk), .rst(rst), .bus(if_hi));
    encoder8x3_pri #(.HIGH_FIRST(1'b0)) u_lo (.clk(clk), .rst(rst), .bus(if_lo));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        if_hi.en = 1'b1; if_hi.req = 8'h00; if_hi.out_ready = 1'b1;
        if_lo.en = 1'b1; if_lo.req = 8'h00; if_lo.out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_pending", if_hi.pending, 8'h00);
        check("rst_valid",   8'(if_hi.out_valid), 8'h00);
        check("rst_code",    8'(if_hi.out_code), 8'h00);
        check("rst_lost",    8'(if_hi.lost), 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_valid", 8'(if_hi.out_valid), 8'h00);
        end

        // High-first burst: 7, 5, 2 back to back
        if_hi.req = 8'b1010_0100;
        tick();
        if_hi.req = 8'h00;
        check("hi_pend", if_hi.pending, 8'hA4);
        check("hi_v0", 8'(if_hi.out_valid), 8'h00);
        tick(); check("hi_c0", 8'(if_hi.out_code), 8'd7); check("hi_v1", 8'(if_hi.out_valid), 8'h01);
        tick(); check("hi_c1", 8'(if_hi.out_code), 8'd5); check("hi_v2", 8'(if_hi.out_valid), 8'h01);
        tick(); check("hi_c2", 8'(if_hi.out_code), 8'd2); check("hi_v3", 8'(if_hi.out_valid), 8'h01);
        tick(); check("hi_vend", 8'(if_hi.out_valid), 8'h00); check("hi_pend_end", if_hi.pending, 8'h00);

        // Low-first burst: 2, 5, 7
        if_lo.req = 8'b1010_0100;
        tick();
        if_lo.req = 8'h00;
        tick(); check("lo_c0", 8'(if_lo.out_code), 8'd2); check("lo_v1", 8'(if_lo.out_valid), 8'h01);
        tick(); check("lo_c1", 8'(if_lo.out_code), 8'd5);
        tick(); check("lo_c2", 8'(if_lo.out_code), 8'd7);
        tick(); check("lo_vend", 8'(if_lo.out_valid), 8'h00); check("lo_pend_end", if_lo.pending, 8'h00);

        // Stall: code 3 held while req[6] arrives, no preemption
        if_hi.out_ready = 1'b0;
        if_hi.req = 8'h08;
        tick();
        if_hi.req = 8'h00;
        tick(); check("st_c3", 8'(if_hi.out_code), 8'd3); check("st_v", 8'(if_hi.out_valid), 8'h01);
        if_hi.req = 8'h40;
        tick();
        if_hi.req = 8'h00;
        check("st_hold", 8'(if_hi.out_code), 8'd3);
        check("st_pend", if_hi.pending, 8'h48);
        tick(); check("st_hold2", 8'(if_hi.out_code), 8'd3);
        if_hi.out_ready = 1'b1;
        tick(); check("st_c6", 8'(if_hi.out_code), 8'd6); check("st_pend2", if_hi.pending, 8'h40);
        tick(); check("st_vend", 8'(if_hi.out_valid), 8'h00);

        // Request on the accepting edge wins over the clear, not lost
        if_hi.req = 8'h10;
        tick();
        if_hi.req = 8'h00;
        tick(); check("rc_c4", 8'(if_hi.out_code), 8'd4);
        if_hi.req = 8'h10;
        tick();
        if_hi.req = 8'h00;
        if_hi.out_ready = 1'b0;
        check("rc_pend", if_hi.pending, 8'h10);
        check("rc_lost", 8'(if_hi.lost), 8'h00);
        tick(); check("rc_c4b", 8'(if_hi.out_code), 8'd4); check("rc_vb", 8'(if_hi.out_valid), 8'h01);
        // req[1] twice with out_ready=0: second one is dropped
        if_hi.req = 8'h02;
        tick(); check("lost_first", 8'(if_hi.lost), 8'h00); check("lost_pend", if_hi.pending, 8'h12);
        tick();
        if_hi.req = 8'h00;
        check("lost_set", 8'(if_hi.lost), 8'h01);
        if_hi.out_ready = 1'b1;
        tick(); check("lost_c1", 8'(if_hi.out_code), 8'd1);
        tick(); check("lost_vend", 8'(if_hi.out_valid), 8'h00);

        // en=0: accept still clears, req ignored, no reload
        if_hi.out_ready = 1'b0;
        if_hi.req = 8'h05;
        tick();
        if_hi.req = 8'h00;
        tick(); check("en_c2", 8'(if_hi.out_code), 8'd2);
        if_hi.en = 1'b0;
        if_hi.req = 8'hFF;
        if_hi.out_ready = 1'b1;
        tick();
        check("en_vdrop", 8'(if_hi.out_valid), 8'h00);
        check("en_pend", if_hi.pending, 8'h01);
        tick();
        check("en_freeze", 8'(if_hi.out_valid), 8'h00);
        check("en_pend2", if_hi.pending, 8'h01);
        if_hi.en = 1'b1;
        if_hi.req = 8'h00;
        tick(); check("en_c0", 8'(if_hi.out_code), 8'd0); check("en_v", 8'(if_hi.out_valid), 8'h01);
        tick(); check("en_vend", 8'(if_hi.out_valid), 8'h00);

        // Asynchronous reset in the middle of HOLD
        if_hi.out_ready = 1'b0;
        if_hi.req = 8'h80;
        tick();
        if_hi.req = 8'h00;
        tick(); check("ar_c7", 8'(if_hi.out_code), 8'd7); check("ar_v", 8'(if_hi.out_valid), 8'h01);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 8'(if_hi.out_valid), 8'h00);
        check("ar_code",  8'(if_hi.out_code), 8'h00);
        check("ar_pend",  if_hi.pending, 8'h00);
        check("ar_lost",  8'(if_hi.lost), 8'h00);
        tick();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
